hazard_controller: RTL and testbench

Pipeline sequencing controller for the decode stage of the 5-stage MIPS32 pipeline. Detects load-use and branch-operand hazards against the instruction in IF/ID, then inserts bubbles through `Stall_EN` while holding the PC and IF/ID registers. Squashes the wrong-path fetch on a taken branch or jump resolved in ID. Keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_controller_if.sv | 39 +++
 rtl/hazard_controller.sv | 107 ++++++++++
 tb/tb_hazard_controller.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - decode-stage hazard bundle between pipeline and hazard_controller
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  // Decode-stage instruction fields
  logic [4:0]       IF_ID_rs_field;
  logic [4:0]       IF_ID_rt_field;
  logic             IF_ID_Branch;
  logic             IF_ID_Jump;
  logic             Branch_taken;
  // Downstream stage state
  logic             ID_EX_MemRead;
  logic             ID_EX_RegWrite;
  logic [4:0]       ID_EX_wr_addr;
  logic             EX_MEM_MemRead;
  logic [4:0]       EX_MEM_wr_addr;
  // Sequencing controls back to the pipeline
  logic             Stall_EN;
  logic             PC_Hold;
  logic             IF_ID_Hold;
  logic             IF_ID_Flush;
  // Performance counters
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: presents decode/EX/MEM state, consumes controls
  modport master (
    output IF_ID_rs_field, IF_ID_rt_field, IF_ID_Branch, IF_ID_Jump, Branch_taken,
    output ID_EX_MemRead, ID_EX_RegWrite, ID_EX_wr_addr, EX_MEM_MemRead, EX_MEM_wr_addr,
    input  Stall_EN, PC_Hold, IF_ID_Hold, IF_ID_Flush, stall_cycles, flush_count
  );

  // Controller side
  modport slave (
    input  IF_ID_rs_field, IF_ID_rt_field, IF_ID_Branch, IF_ID_Jump, Branch_taken,
    input  ID_EX_MemRead, ID_EX_RegWrite, ID_EX_wr_addr, EX_MEM_MemRead, EX_MEM_wr_addr,
    output Stall_EN, PC_Hold, IF_ID_Hold, IF_ID_Flush, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - MIPS32 decode-stage stall/flush sequencer with saturating perf counters
module hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_controller_if.slave  hz
);

  typedef enum logic {
    RUN   = 1'b0,
    HOLD1 = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_match, mem_match;
  logic lu_haz, br_alu_haz, br_ld_haz, br_mem_haz, any_haz;
  logic stall, flush;

  // Register $0 is hardwired to zero, so it can never be a true dependency.
  function automatic logic addr_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  assign ex_match  = addr_match(hz.ID_EX_wr_addr, hz.IF_ID_rs_field) |
                     addr_match(hz.ID_EX_wr_addr, hz.IF_ID_rt_field);
  assign mem_match = addr_match(hz.EX_MEM_wr_addr, hz.IF_ID_rs_field) |
                     addr_match(hz.EX_MEM_wr_addr, hz.IF_ID_rt_field);

  // Branches resolve in ID, so they need operands earlier than ordinary ALU users.
  assign lu_haz     = hz.ID_EX_MemRead & ex_match;
  assign br_alu_haz = hz.IF_ID_Branch & hz.ID_EX_RegWrite & ~hz.ID_EX_MemRead & ex_match;
  assign br_ld_haz  = hz.IF_ID_Branch & hz.ID_EX_MemRead & ex_match;
  assign br_mem_haz = hz.IF_ID_Branch & hz.EX_MEM_MemRead & mem_match;
  assign any_haz    = lu_haz | br_alu_haz | br_ld_haz | br_mem_haz;

  // State register; reset from any state lands in RUN so no stall leaks past reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: only a branch waiting on a load needs the second bubble
  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN:     state_d = br_ld_haz ? HOLD1 : RUN;
      HOLD1:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs: stall wins over flush because branch operands are not valid while stalling
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN:     stall = any_haz;
        HOLD1:   stall = 1'b1;
        default: stall = 1'b0;
      endcase
      flush = ~stall & (hz.IF_ID_Jump | (hz.IF_ID_Branch & hz.Branch_taken));
    end
  end

  assign hz.Stall_EN    = stall;
  assign hz.PC_Hold     = stall;
  assign hz.IF_ID_Hold  = stall;
  assign hz.IF_ID_Flush = flush;

  // Counter next-state: saturate at all-ones instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Counters read as zero for the whole reset cycle, not just after the edge
  assign hz.stall_cycles = rst ? '0 : stall_cnt_q;
  assign hz.flush_count  = rst ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(4)) hif ();

  hazard_controller #(.CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clean();
    hif.IF_ID_rs_field = 5'd0;
    hif.IF_ID_rt_field = 5'd0;
    hif.IF_ID_Branch   = 1'b0;
    hif.IF_ID_Jump     = 1'b0;
    hif.Branch_taken   = 1'b0;
    hif.ID_EX_MemRead  = 1'b0;
    hif.ID_EX_RegWrite = 1'b0;
    hif.ID_EX_wr_addr  = 5'd0;
    hif.EX_MEM_MemRead = 1'b0;
    hif.EX_MEM_wr_addr = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic f);
    chk({tag, ".stall"}, {31'd0, hif.Stall_EN}, {31'd0, s});
    chk({tag, ".pchold"}, {31'd0, hif.PC_Hold}, {31'd0, s});
    chk({tag, ".ifidhold"}, {31'd0, hif.IF_ID_Hold}, {31'd0, s});
    chk({tag, ".flush"}, {31'd0, hif.IF_ID_Flush}, {31'd0, f});
  endtask

  task automatic chk_cnt(input string tag, input int sc, input int fc);
    chk({tag, ".stall_cycles"}, {28'd0, hif.stall_cycles}, sc);
    chk({tag, ".flush_count"}, {28'd0, hif.flush_count}, fc);
  endtask

  task automatic do_reset();
    clean();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    // Reset with a load-use hazard present: everything must read 0
    clean();
    hif.ID_EX_MemRead  = 1'b1;
    hif.ID_EX_wr_addr  = 5'd5;
    hif.IF_ID_rs_field = 5'd5;
    hif.IF_ID_Jump     = 1'b1;
    rst = 1'b1;
    tick();
    settle();
    chk_ctl("rst_hazard", 1'b0, 1'b0);
    chk_cnt("rst_hazard", 0, 0);
    tick();
    do_reset();
    chk_ctl("post_rst", 1'b0, 1'b0);
    chk_cnt("post_rst", 0, 0);

    // Load-use: lw $5 in EX, rs=5 in ID -> one stall cycle
    hif.ID_EX_MemRead  = 1'b1;
    hif.ID_EX_wr_addr  = 5'd5;
    hif.IF_ID_rs_field = 5'd5;
    settle();
    chk_ctl("lu_c0", 1'b1, 1'b0);
    tick();
    clean();
    hif.IF_ID_rs_field = 5'd5;
    hif.EX_MEM_MemRead = 1'b1;
    hif.EX_MEM_wr_addr = 5'd5;
    settle();
    chk_ctl("lu_c1", 1'b0, 1'b0);
    chk_cnt("lu_c1", 1, 0);

    // Branch after load: lw $8 in EX, beq rt=8 taken -> two stalls, then flush
    do_reset();
    hif.ID_EX_MemRead  = 1'b1;
    hif.ID_EX_wr_addr  = 5'd8;
    hif.IF_ID_Branch   = 1'b1;
    hif.IF_ID_rt_field = 5'd8;
    hif.Branch_taken   = 1'b1;
    settle();
    chk_ctl("brld_c0", 1'b1, 1'b0);
    tick();
    hif.ID_EX_MemRead  = 1'b0;
    hif.ID_EX_wr_addr  = 5'd0;
    hif.EX_MEM_MemRead = 1'b1;
    hif.EX_MEM_wr_addr = 5'd8;
    settle();
    chk_ctl("brld_c1", 1'b1, 1'b0);
    chk_cnt("brld_c1", 1, 0);
    tick();
    hif.EX_MEM_MemRead = 1'b0;
    hif.EX_MEM_wr_addr = 5'd0;
    settle();
    chk_ctl("brld_c2", 1'b0, 1'b1);
    tick();
    clean();
    settle();
    chk_ctl("brld_c3", 1'b0, 1'b0);
    chk_cnt("brld_c3", 2, 1);

    // $0 destination never hazards
    do_reset();
    hif.ID_EX_MemRead  = 1'b1;
    hif.ID_EX_RegWrite = 1'b1;
    hif.EX_MEM_MemRead = 1'b1;
    settle();
    chk_ctl("zero_c0", 1'b0, 1'b0);
    tick();
    chk_ctl("zero_c1", 1'b0, 1'b0);
    chk_cnt("zero_c1", 0, 0);

    // Plain jump flushes immediately
    do_reset();
    hif.IF_ID_Jump = 1'b1;
    settle();
    chk_ctl("jmp_c0", 1'b0, 1'b1);
    tick();
    clean();
    settle();
    chk_cnt("jmp_c1", 0, 1);

    // Jump with load-use hazard: held first, flushed once hazard clears
    hif.IF_ID_Jump     = 1'b1;
    hif.ID_EX_MemRead  = 1'b1;
    hif.ID_EX_wr_addr  = 5'd9;
    hif.IF_ID_rt_field = 5'd9;
    settle();
    chk_ctl("jmphz_c0", 1'b1, 1'b0);
    tick();
    hif.ID_EX_MemRead = 1'b0;
    hif.ID_EX_wr_addr = 5'd0;
    settle();
    chk_ctl("jmphz_c1", 1'b0, 1'b1);
    tick();
    clean();
    settle();
    chk_cnt("jmphz_c2", 1, 2);

    // Branch on ALU result in EX: one stall, then taken branch flushes
    do_reset();
    hif.IF_ID_Branch   = 1'b1;
    hif.Branch_taken   = 1'b1;
    hif.IF_ID_rs_field = 5'd3;
    hif.ID_EX_RegWrite = 1'b1;
    hif.ID_EX_wr_addr  = 5'd3;
    settle();
    chk_ctl("bralu_c0", 1'b1, 1'b0);
    tick();
    hif.ID_EX_RegWrite = 1'b0;
    hif.ID_EX_wr_addr  = 5'd0;
    settle();
    chk_ctl("bralu_c1", 1'b0, 1'b1);

    // Reset asserted while in HOLD1
    do_reset();
    hif.ID_EX_MemRead  = 1'b1;
    hif.ID_EX_wr_addr  = 5'd4;
    hif.IF_ID_Branch   = 1'b1;
    hif.IF_ID_rs_field = 5'd4;
    settle();
    chk_ctl("rsth_c0", 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    settle();
    chk_ctl("rsth_inrst", 1'b0, 1'b0);
    chk_cnt("rsth_inrst", 0, 0);
    tick();
    rst = 1'b0;
    clean();
    settle();
    chk_ctl("rsth_after", 1'b0, 1'b0);
    chk_cnt("rsth_after", 0, 0);
    tick();
    chk_ctl("rsth_after2", 1'b0, 1'b0);

    // Saturation: BR_MEM held for 20 cycles with a taken branch that must not flush
    do_reset();
    hif.IF_ID_Branch   = 1'b1;
    hif.Branch_taken   = 1'b1;
    hif.IF_ID_rs_field = 5'd7;
    hif.EX_MEM_MemRead = 1'b1;
    hif.EX_MEM_wr_addr = 5'd7;
    settle();
    chk_ctl("sat_c0", 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk_cnt("sat_15", 15, 0);
    for (int i = 0; i < 5; i++) tick();
    chk_ctl("sat_c20", 1'b1, 1'b0);
    chk_cnt("sat_20", 15, 0);

    clean();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
